// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack controller.
// The optional coroutine handling is selected by RAS_COROUTINE_EN in ras_ctrl.
package ras_pkg;

   localparam int unsigned RAS_DW = 32;

   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;
   localparam logic [2:0] F3_JALR  = 3'b000;
   localparam logic [4:0] REG_RA   = 5'd1;
   localparam logic [4:0] REG_T0   = 5'd5;

   typedef enum logic {
      OP_PUSH = 1'b0,
      OP_RET  = 1'b1
   } op_kind_e;

   typedef struct packed {
      op_kind_e            kind;
      logic [RAS_DW-1:0]   data;
      logic [RAS_DW-1:0]   pc;
   } ras_op_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      CHECK = 2'd1,
      FAULT = 2'd2
   } state_e;

   function automatic logic is_link(input logic [4:0] r);
      return (r == REG_RA) || (r == REG_T0);
   endfunction

endpackage

// File: rtl/ras_op_fifo.sv
// Circular queue of decoded stack operations: up to two entries enqueued and
// one dequeued per cycle; flush empties it and overrides any same-cycle enqueue.
module ras_op_fifo
   import ras_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic [1:0]                 i_enq_n,
   input  ras_op_t                    i_enq_a,
   input  ras_op_t                    i_enq_b,
   input  logic                       i_deq,
   output ras_op_t                    o_head,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_free
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   ras_op_t         r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   w_wptr1;

   assign w_wptr1 = r_wptr + AW'(1);
   assign o_head  = r_mem[r_rptr];
   assign o_empty = (r_count == CW'(0));
   assign o_free  = CW'(DEPTH) - r_count;

   // Pointer and occupancy update; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + AW'(i_enq_n);
         r_rptr  <= r_rptr + AW'(i_deq);
         r_count <= r_count + CW'(i_enq_n) - CW'(i_deq);
      end
   end

   // Entry storage; a coroutine writes two consecutive slots at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (!i_flush) begin
         if (i_enq_n != 2'd0) begin
            r_mem[r_wptr] <= i_enq_a;
         end
         if (i_enq_n == 2'd2) begin
            r_mem[w_wptr1] <= i_enq_b;
         end
      end
   end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: decodes committed calls/returns, queues them and
// drives the stack one command per cycle. Optional feature macro: RAS_COROUTINE_EN.
module ras_ctrl
   import ras_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RAS_DW,
   parameter int unsigned QDEPTH     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_instr,
   input  logic [DATA_WIDTH-1:0]   in_pc,
   input  logic [DATA_WIDTH-1:0]   in_target,
   output logic                    stack_ena,
   output logic                    stack_push,
   output logic                    stack_pop,
   output logic                    stack_ret,
   output logic [DATA_WIDTH-1:0]   stack_din,
   input  logic                    stack_full,
   input  logic                    stack_empty,
   input  logic                    stack_mismatch,
   output logic                    fault,
   output logic [DATA_WIDTH-1:0]   fault_pc,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;
`ifdef RAS_COROUTINE_EN
   localparam logic [CW-1:0] NEED_FREE = CW'(2);
`else
   localparam logic [CW-1:0] NEED_FREE = CW'(1);
`endif

   state_e                  r_state;
   logic [DATA_WIDTH-1:0]   r_chk_pc;
   logic                    r_fault;
   logic [DATA_WIDTH-1:0]   r_fault_pc;
   logic                    r_ovf;
   logic                    r_unf;

   state_e          w_next;
   logic            w_accept;
   logic [6:0]      w_opc;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic [2:0]      w_f3;
   logic            w_rd_link;
   logic            w_rs1_link;
   ras_op_t         w_push_op;
   ras_op_t         w_ret_op;
   logic [1:0]      w_enq_n;
   ras_op_t         w_enq_a;
   ras_op_t         w_enq_b;
   logic            w_deq;
   logic            w_flush;
   logic            w_issue_ret;
   logic            w_set_ovf;
   logic            w_set_unf;
   ras_op_t         w_head;
   logic            w_empty;
   logic [CW-1:0]   w_free;
   logic            w_unused;

   assign w_opc      = in_instr[6:0];
   assign w_rd       = in_instr[11:7];
   assign w_f3       = in_instr[14:12];
   assign w_rs1      = in_instr[19:15];
   assign w_unused   = &{1'b0, in_instr[31:20]};
   assign w_rd_link  = is_link(w_rd);
   assign w_rs1_link = is_link(w_rs1);

   assign in_ready  = ~rst & (r_state != FAULT) & (w_free >= NEED_FREE);
   assign w_accept  = in_valid & in_ready;
   assign stack_pop = 1'b0;
   assign fault     = r_fault;
   assign fault_pc  = r_fault_pc;
   assign overflow  = r_ovf;
   assign underflow = r_unf;

   // Candidate queue entries for the instruction being accepted.
   always_comb begin
      w_push_op.kind = OP_PUSH;
      w_push_op.data = in_pc + DATA_WIDTH'(4);
      w_push_op.pc   = in_pc;
      w_ret_op.kind  = OP_RET;
      w_ret_op.data  = in_target;
      w_ret_op.pc    = in_pc;
   end

   // Call/return classification; a coroutine puts its return ahead of its push.
   always_comb begin
      w_enq_n = 2'd0;
      w_enq_a = w_push_op;
      w_enq_b = w_push_op;
      if (w_accept && (w_opc == OPC_JAL)) begin
         w_enq_n = w_rd_link ? 2'd1 : 2'd0;
      end else if (w_accept && (w_opc == OPC_JALR) && (w_f3 == F3_JALR)) begin
         case ({w_rd_link, w_rs1_link})
            2'b10: w_enq_n = 2'd1;
            2'b01: begin
               w_enq_n = 2'd1;
               w_enq_a = w_ret_op;
            end
            2'b11: begin
               if (w_rd == w_rs1) begin
                  w_enq_n = 2'd1;
               end else begin
`ifdef RAS_COROUTINE_EN
                  w_enq_n = 2'd2;
                  w_enq_a = w_ret_op;
                  w_enq_b = w_push_op;
`else
                  w_enq_n = 2'd1;
`endif
               end
            end
            default: w_enq_n = 2'd0;
         endcase
      end else begin
         w_enq_n = 2'd0;
      end
   end

   ras_op_fifo #(
      .DEPTH   (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_enq_n (w_enq_n),
      .i_enq_a (w_enq_a),
      .i_enq_b (w_enq_b),
      .i_deq   (w_deq),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_free  (w_free)
   );

   // Issue FSM: a skipped command still consumes its queue entry.
   always_comb begin
      stack_ena   = 1'b0;
      stack_push  = 1'b0;
      stack_ret   = 1'b0;
      w_deq       = 1'b0;
      w_next      = r_state;
      w_flush     = 1'b0;
      w_issue_ret = 1'b0;
      w_set_ovf   = 1'b0;
      w_set_unf   = 1'b0;
      case (r_state)
         RUN: begin
            if (!w_empty) begin
               w_deq = 1'b1;
               if (w_head.kind == OP_PUSH) begin
                  if (stack_full) begin
                     w_set_ovf = 1'b1;
                  end else begin
                     stack_ena  = 1'b1;
                     stack_push = 1'b1;
                  end
               end else begin
                  if (stack_empty) begin
                     w_set_unf = 1'b1;
                  end else begin
                     stack_ena   = 1'b1;
                     stack_ret   = 1'b1;
                     w_issue_ret = 1'b1;
                     w_next      = CHECK;
                  end
               end
            end else begin
               w_deq = 1'b0;
            end
         end
         CHECK: begin
            if (stack_mismatch) begin
               w_next  = FAULT;
               w_flush = 1'b1;
            end else begin
               w_next = RUN;
            end
         end
         FAULT:   w_next = FAULT;
         default: w_next = FAULT;
      endcase
   end

   // Data is only presented while the head is eligible for issue.
   always_comb begin
      if ((r_state == RUN) && !w_empty) begin
         stack_din = w_head.data;
      end else begin
         stack_din = '0;
      end
   end

   // State, pending-check PC and sticky status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RUN;
         r_chk_pc   <= '0;
         r_fault    <= 1'b0;
         r_fault_pc <= '0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_issue_ret) begin
            r_chk_pc <= w_head.pc;
         end
         if (w_flush) begin
            r_fault    <= 1'b1;
            r_fault_pc <= r_chk_pc;
         end
         if (w_set_ovf) begin
            r_ovf <= 1'b1;
         end
         if (w_set_unf) begin
            r_unf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: queue-based reference model plus directed vectors;
// honours RAS_COROUTINE_EN when it is defined for the build.
module tb_ras_ctrl;

   localparam int QD    = 4;
   localparam int SDEPTH = 16;
`ifdef RAS_COROUTINE_EN
   localparam int NEED = 2;
   localparam bit COR  = 1'b1;
`else
   localparam int NEED = 1;
   localparam bit COR  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_target = '0;
   logic        stack_ena, stack_push, stack_pop, stack_ret;
   logic [31:0] stack_din;
   logic        stack_full, stack_empty, stack_mismatch;
   logic        fault, overflow, underflow;
   logic [31:0] fault_pc;

   int n_vec = 0;
   int n_err = 0;
   int bp_cnt = 0;

   // environment stack
   logic [31:0] stk [SDEPTH];
   int          sp;
   logic        env_mm;
   bit          force_full = 1'b0;
   bit          force_empty = 1'b0;

   always #5 clk = ~clk;

   ras_ctrl #(.DATA_WIDTH(32), .QDEPTH(QD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_target(in_target),
      .stack_ena(stack_ena), .stack_push(stack_push), .stack_pop(stack_pop),
      .stack_ret(stack_ret), .stack_din(stack_din), .stack_full(stack_full),
      .stack_empty(stack_empty), .stack_mismatch(stack_mismatch),
      .fault(fault), .fault_pc(fault_pc), .overflow(overflow), .underflow(underflow)
   );

   always_comb begin
      stack_full     = force_full | (sp == SDEPTH);
      stack_empty    = force_empty | (sp == 0);
      stack_mismatch = env_mm;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sp     <= 0;
         env_mm <= 1'b0;
      end else begin
         env_mm <= 1'b0;
         if (stack_ena && stack_push && sp < SDEPTH) begin
            stk[sp] <= stack_din;
            sp      <= sp + 1;
         end else if (stack_ena && stack_ret) begin
            if (sp == 0) begin
               env_mm <= 1'b1;
            end else begin
               env_mm <= (stk[sp-1] != stack_din);
               sp     <= sp - 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // reference model: pending operations as a queue, mode 0=running 1=checking 2=faulted
   typedef struct { bit is_ret; logic [31:0] data; logic [31:0] pc; } mop_t;
   mop_t        mq[$];
   int          mmode = 0;
   bit          m_fault, m_ovf, m_unf, m_flush;
   logic [31:0] m_fpc, m_cpc;
   bit          e_rdy, e_ena, e_push, e_ret;
   logic [31:0] e_din;
   mop_t        h;

   task automatic m_decode(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] tgt);
      logic [4:0] rd, rs1;
      bit rdl, rsl;
      mop_t p, r;
      rd  = ins[11:7];
      rs1 = ins[19:15];
      rdl = (rd == 5'd1) || (rd == 5'd5);
      rsl = (rs1 == 5'd1) || (rs1 == 5'd5);
      p = '{1'b0, pc + 32'd4, pc};
      r = '{1'b1, tgt, pc};
      if (ins[6:0] == 7'h6F) begin
         if (rdl) mq.push_back(p);
      end else if (ins[6:0] == 7'h67 && ins[14:12] == 3'd0) begin
         if (rdl && rsl && rd != rs1) begin
            if (COR) mq.push_back(r);
            mq.push_back(p);
         end else if (rdl) begin
            mq.push_back(p);
         end else if (rsl) begin
            mq.push_back(r);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         mmode = 0; m_fault = 0; m_ovf = 0; m_unf = 0; m_fpc = '0; m_cpc = '0;
         chk("m_rst_ready", in_ready, 32'd0);
         chk("m_rst_ena", {stack_ena, stack_push, stack_pop, stack_ret}, 32'd0);
         chk("m_rst_din", stack_din, 32'd0);
         chk("m_rst_flags", {fault, overflow, underflow}, 32'd0);
         chk("m_rst_fpc", fault_pc, 32'd0);
      end else begin
         e_rdy = (mmode != 2) && (QD - mq.size() >= NEED);
         e_ena = 0; e_push = 0; e_ret = 0; e_din = '0;
         if (mmode == 0 && mq.size() > 0) begin
            h = mq[0];
            if (!h.is_ret && !stack_full) begin
               e_ena = 1; e_push = 1; e_din = h.data;
            end else if (h.is_ret && !stack_empty) begin
               e_ena = 1; e_ret = 1; e_din = h.data;
            end
         end
         chk("m_ready", in_ready, e_rdy);
         chk("m_ena", stack_ena, e_ena);
         chk("m_push", stack_push, e_push);
         chk("m_pop", stack_pop, 32'd0);
         chk("m_ret", stack_ret, e_ret);
         if (e_ena) chk("m_din", stack_din, e_din);
         chk("m_fault", fault, m_fault);
         chk("m_fault_pc", fault_pc, m_fpc);
         chk("m_overflow", overflow, m_ovf);
         chk("m_underflow", underflow, m_unf);
         // advance to the state after the coming edge
         m_flush = 0;
         if (mmode == 0 && mq.size() > 0) begin
            h = mq.pop_front();
            if (!h.is_ret) begin
               if (stack_full) m_ovf = 1;
            end else if (stack_empty) begin
               m_unf = 1;
            end else begin
               mmode = 1;
               m_cpc = h.pc;
            end
         end else if (mmode == 1) begin
            if (stack_mismatch) begin
               mmode = 2; m_fault = 1; m_fpc = m_cpc; m_flush = 1;
            end else begin
               mmode = 0;
            end
         end
         if (in_valid && e_rdy) m_decode(in_instr, in_pc, in_target);
         if (m_flush) mq.delete();
      end
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] tgt);
      bit   done;
      logic rdy;
      done      = 1'b0;
      in_valid  = 1'b1;
      in_instr  = ins;
      in_pc     = pc;
      in_target = tgt;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         rdy = in_ready;
         if (!rdy) bp_cnt++;
         @(posedge clk);
         #1;
         if (rdy) done = 1'b1;
      end
      in_valid = 1'b0;
      chk("accept", done, 32'd1);
   endtask

   initial begin
      #100000;
      n_err++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ready", in_ready, 32'd0);
      chk("rst_ena", stack_ena, 32'd0);
      edge1();
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", in_ready, 32'd1);
      edge1();

      // ADD enqueues nothing
      send(32'h003100B3, 32'h50, 32'h0);
      @(negedge clk); chk("add_no_op", stack_ena, 32'd0);
      edge1();

      // JAL x1 -> push pc+4 one cycle after accept
      send(32'h000000EF, 32'h100, 32'h0);
      @(negedge clk);
      chk("jal_push", stack_push, 32'd1);
      chk("jal_din", stack_din, 32'h104);
      edge1();

      // matching return: issue, CHECK, back to RUN
      send(32'h00008067, 32'h300, 32'h104);
      @(negedge clk);
      chk("ret_issue", stack_ret, 32'd1);
      chk("ret_din", stack_din, 32'h104);
      edge1();
      @(negedge clk); chk("check_idle", stack_ena, 32'd0);
      edge1();
      @(negedge clk);
      chk("ret_ok_fault", fault, 32'd0);
      chk("ret_ok_ready", in_ready, 32'd1);
      edge1();

      // back-to-back calls, all pushed in order
      for (int i = 0; i < 8; i++) send(32'h000000EF, 32'h1000 + 32'(4 * i), 32'h0);
      repeat (3) edge1();
      chk("call_depth", sp, 32'd8);
      for (int i = 0; i < 8; i++) chk("call_order", stk[i], 32'h1004 + 32'(4 * i));

      // returns arrive faster than they drain -> back-pressure
      bp_cnt = 0;
      for (int i = 0; i < 8; i++) send(32'h00008067, 32'h2000 + 32'(4 * i), 32'h1020 - 32'(4 * i));
      repeat (20) edge1();
      chk("backpressure_seen", (bp_cnt > 0), 32'd1);
      chk("rets_drained", sp, 32'd0);
      chk("rets_no_fault", fault, 32'd0);

      // push dropped on full
      force_full = 1'b1;
      send(32'h000002EF, 32'h400, 32'h0);
      @(negedge clk); chk("ovf_skip", stack_ena, 32'd0);
      edge1();
      @(negedge clk);
      chk("ovf_flag", overflow, 32'd1);
      chk("ovf_depth", sp, 32'd0);
      edge1();
      force_full = 1'b0;

      // return skipped on empty, next op issues without a CHECK gap
      force_empty = 1'b1;
      send(32'h00008067, 32'h500, 32'h1008);
      send(32'h000000EF, 32'h600, 32'h0);
      @(negedge clk);
      chk("unf_flag", underflow, 32'd1);
      chk("unf_next_push", stack_push, 32'd1);
      chk("unf_next_din", stack_din, 32'h604);
      edge1();
      force_empty = 1'b0;
      repeat (2) edge1();

      // coroutine JALR x1,0(x5)
      send(32'h000280E7, 32'h700, 32'h604);
`ifdef RAS_COROUTINE_EN
      @(negedge clk);
      chk("co_ret", stack_ret, 32'd1);
      chk("co_ret_din", stack_din, 32'h604);
      edge1();
      @(negedge clk); chk("co_check", stack_ena, 32'd0);
      edge1();
      @(negedge clk);
      chk("co_push", stack_push, 32'd1);
      chk("co_push_din", stack_din, 32'h704);
`else
      @(negedge clk);
      chk("co_push_only", stack_push, 32'd1);
      chk("co_push_din", stack_din, 32'h704);
`endif
      edge1();
      repeat (2) edge1();

      // mismatching return -> fault, queued call flushed, permanently blocked
      send(32'h00008067, 32'h800, 32'h200);
      in_valid = 1'b1; in_instr = 32'h000000EF; in_pc = 32'h900;
      @(negedge clk); chk("bad_ret_issue", stack_ret, 32'd1);
      edge1();
      @(negedge clk); chk("bad_ret_check", stack_ena, 32'd0);
      edge1();
      @(negedge clk);
      chk("fault_set", fault, 32'd1);
      chk("fault_pc", fault_pc, 32'h800);
      chk("fault_ready", in_ready, 32'd0);
      repeat (5) edge1();
      @(negedge clk);
      chk("fault_hold_ready", in_ready, 32'd0);
      chk("fault_hold_ena", stack_ena, 32'd0);
      chk("fault_hold", fault, 32'd1);
      in_valid = 1'b0;

      // reset clears everything
      edge1();
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_fault", fault, 32'd0);
      chk("rst2_fpc", fault_pc, 32'd0);
      chk("rst2_flags", {overflow, underflow}, 32'd0);
      edge1();
      rst = 1'b0;
      @(negedge clk); chk("rst2_ready", in_ready, 32'd1);
      edge1();
      send(32'h000000EF, 32'h100, 32'h0);
      @(negedge clk);
      chk("post_rst_push", stack_push, 32'd1);
      chk("post_rst_din", stack_din, 32'h104);
      repeat (3) edge1();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
